// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, MemtoReg encodings,
// the bundled enable/flush control word and the load-use match helper.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } haz_state_e;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

  typedef struct packed {
    logic pc_en;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic flush_ifid;
    logic flush_idex;
    logic flush_memwb;
  } haz_ctrl_t;

  // A load whose result is read by the instruction directly behind it; x0 never matches.
  function automatic logic load_use_hit(
    input logic [4:0] rs1_addr,
    input logic       rs1_used,
    input logic [4:0] rs2_addr,
    input logic       rs2_used,
    input logic [4:0] rd_addr,
    input logic       reg_write,
    input logic [1:0] mem_to_reg
  );
    logic rs1_hit;
    logic rs2_hit;
    rs1_hit = rs1_used && (rs1_addr == rd_addr);
    rs2_hit = rs2_used && (rs2_addr == rd_addr);
    return reg_write && (mem_to_reg == MEMTOREG_LOAD) && (rd_addr != 5'd0) &&
           (rs1_hit || rs2_hit);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating stall-cycle and flush-event counters for the hazard controller.
// Instantiated only when HAZ_PERF_CNT_EN is defined.
module hazard_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush_i && (flush_q != 32'hFFFF_FFFF)) begin
      flush_d = flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with a memory-wait timeout FSM.
// Define HAZ_PERF_CNT_EN to add the stall_cycles/flush_events performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_HAZ,
  input  logic        rst_n_HAZ,
  input  logic [4:0]  Rs1_addr_ID,
  input  logic [4:0]  Rs2_addr_ID,
  input  logic        Rs1_used_ID,
  input  logic        Rs2_used_ID,
  input  logic [4:0]  Rd_addr_EX,
  input  logic        RegWrite_EX,
  input  logic [1:0]  MemtoReg_EX,
  input  logic        Branch_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready_MEM,
  output logic        PC_en,
  output logic        en_IFID,
  output logic        en_IDEX,
  output logic        en_EXMEM,
  output logic        en_MEMWB,
  output logic        flush_IFID,
  output logic        flush_IDEX,
  output logic        flush_MEMWB,
  output logic        mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

  haz_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  haz_ctrl_t       ctrl;
  logic            err;
  logic            mem_wait;
  logic            load_use;

  assign mem_wait = mem_req_MEM && !mem_ready_MEM;
  assign load_use = load_use_hit(Rs1_addr_ID, Rs1_used_ID, Rs2_addr_ID, Rs2_used_ID,
                                 Rd_addr_EX, RegWrite_EX, MemtoReg_EX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_wait) begin
          state_d = StMemWait;
          cnt_d   = CntW'(1);
        end
      end
      StMemWait: begin
        if (!mem_req_MEM || mem_ready_MEM) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutVal) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_HAZ or negedge rst_n_HAZ) begin
    if (!rst_n_HAZ) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset is decoded combinationally so every pipeline register holds while it is low.
  always_comb begin
    ctrl = '0;
    err  = 1'b0;
    if (!rst_n_HAZ) begin
      ctrl = '0;
    end else if (state_q == StErr) begin
      err = 1'b1;
    end else if (mem_wait) begin
      ctrl.en_memwb    = 1'b1;
      ctrl.flush_memwb = 1'b1;
    end else if (Branch_taken_EX) begin
      ctrl.pc_en      = 1'b1;
      ctrl.en_ifid    = 1'b1;
      ctrl.en_idex    = 1'b1;
      ctrl.en_exmem   = 1'b1;
      ctrl.en_memwb   = 1'b1;
      ctrl.flush_ifid = 1'b1;
      ctrl.flush_idex = 1'b1;
    end else if (load_use) begin
      ctrl.en_idex    = 1'b1;
      ctrl.en_exmem   = 1'b1;
      ctrl.en_memwb   = 1'b1;
      ctrl.flush_idex = 1'b1;
    end else begin
      ctrl.pc_en    = 1'b1;
      ctrl.en_ifid  = 1'b1;
      ctrl.en_idex  = 1'b1;
      ctrl.en_exmem = 1'b1;
      ctrl.en_memwb = 1'b1;
    end
  end

  assign PC_en       = ctrl.pc_en;
  assign en_IFID     = ctrl.en_ifid;
  assign en_IDEX     = ctrl.en_idex;
  assign en_EXMEM    = ctrl.en_exmem;
  assign en_MEMWB    = ctrl.en_memwb;
  assign flush_IFID  = ctrl.flush_ifid;
  assign flush_IDEX  = ctrl.flush_idex;
  assign flush_MEMWB = ctrl.flush_memwb;
  assign mem_err     = err;

`ifdef HAZ_PERF_CNT_EN
  hazard_perf_cnt u_perf_cnt (
    .clk_i          (clk_HAZ),
    .rst_ni         (rst_n_HAZ),
    .stall_i        (!ctrl.pc_en && (state_q != StErr)),
    .flush_i        (ctrl.flush_ifid),
    .stall_cycles_o (stall_cycles),
    .flush_events_o (flush_events)
  );
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. Watches ID-stage source registers, the instruction currently in the ID/EX register, EX-stage branch resolution and the data-memory handshake, and drives the enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It is the controlling end of the enable/flush interface that every pipeline register consumes. It owns a small FSM for multi-cycle memory waits with a timeout.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive memory-wait cycles before a fault is declared; legal range 1..65535.
- clk_HAZ  in  1  pipeline clock.
- rst_n_HAZ  in  1  asynchronous, active-low reset.
- Rs1_addr_ID, Rs2_addr_ID  in  5 each  source registers of the instruction in ID.
- Rs1_used_ID, Rs2_used_ID  in  1 each  the instruction in ID actually reads that source.
- Rd_addr_EX  in  5  destination of the instruction in EX (ID/EX output).
- RegWrite_EX  in  1  the instruction in EX writes a register.
- MemtoReg_EX  in  2  2'b01 = load.
- Branch_taken_EX  in  1  branch or jump resolved taken in EX this cycle.
- mem_req_MEM  in  1  the instruction in MEM accesses data memory.
- mem_ready_MEM  in  1  data memory completes the access this cycle.
- PC_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB  out  1 each  register enables.
- flush_IFID, flush_IDEX, flush_MEMWB  out  1 each  synchronous bubble insert (target register loads zeros on the next edge).
- mem_err  out  1  sticky memory-timeout fault.

## Operation
- The FSM has three states: RUN, MEM_WAIT and ERR. Reset enters RUN.
- Outputs are a combinational decode of the state and the current inputs.
- Each cycle, the output set is chosen in this priority order:
  1. **ERR:** all enables 0, all flushes 0, mem_err=1. The block leaves ERR only on reset.
  2. **Memory wait** (mem_req_MEM & !mem_ready_MEM, in RUN or MEM_WAIT):
     - PC_en, en_IFID, en_IDEX and en_EXMEM are 0.
     - en_MEMWB=1 and flush_MEMWB=1, so a bubble goes to WB.
     - Branch_taken_EX and load-use are ignored, because the upstream stages are frozen and will re-present them.
  3. **Branch taken:** all enables 1, flush_IFID=1, flush_IDEX=1. The PC loads the target.
  4. **Load-use** (RegWrite_EX & MemtoReg_EX==2'b01 & Rd_addr_EX!=0 & ((Rs1_used_ID & Rs1_addr_ID==Rd_addr_EX) | (Rs2_used_ID & Rs2_addr_ID==Rd_addr_EX))):
     - PC_en=0 and en_IFID=0.
     - en_IDEX=1 with flush_IDEX=1, so a bubble enters EX.
     - Downstream enables are 1.
  5. **Otherwise:** all enables 1, all flushes 0.
- FSM transitions:
  - RUN to MEM_WAIT when a memory wait is detected; the wait counter loads 1.
  - MEM_WAIT to RUN on mem_ready_MEM, or when mem_req_MEM drops; the counter clears.
  - MEM_WAIT to ERR when the counter equals MEM_TIMEOUT and the access is still not ready.
  - MEM_WAIT to MEM_WAIT otherwise; the counter increments.
- Wait counter width is $clog2(MEM_TIMEOUT+1). The counter never wraps, because ERR is reached first.
- Register x0 never causes a stall.

## Timing
- While rst_n_HAZ is low, all outputs are 0. This holds all pipeline registers.
- Reset asserted mid-wait returns the block to RUN with the counter at 0 and mem_err at 0.
- First edge after reset release, with no hazard: all enables 1.
- Zero-cycle decision latency: controls reflect the same-cycle inputs.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, so the match clears.
- A memory wait of N cycles (mem_ready_MEM high on wait cycle N+1) freezes the pipeline for N cycles. ERR requires N ≥ MEM_TIMEOUT+1.
- Branch during a memory wait is acted on in the first cycle after mem_ready_MEM.
- Branch and load-use in the same cycle: the branch wins and no stall is taken.

## Configuration
- HAZ_PERF_CNT_EN defined: adds two outputs.
  - stall_cycles[31:0] counts cycles with PC_en=0 while not in ERR.
  - flush_events[31:0] counts cycles with flush_IFID=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- HAZ_PERF_CNT_EN undefined: those ports and registers do not exist; behaviour is otherwise identical.

## Structure
- Shared pipeline package holds:
  - the state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2);
  - the MemtoReg encodings (MEMTOREG_LOAD=2'b01);
  - a hazard-control struct bundling the enable and flush bits.
- Optional sub-module: hazard_perf_cnt (saturating counter pair) instantiated only under HAZ_PERF_CNT_EN.

## Test plan
- **Load-use:** load x5 in EX, add x6,x5,x1 in ID with Rs1_used=1 → one cycle of PC_en=0, en_IFID=0, flush_IDEX=1, then all enables 1.
- **x0 and unused source:** Rd_addr_EX=0, or a matching source with its used flag 0 → no stall.
- **Branch vs. load-use:** Branch_taken_EX=1 together with a load-use match → flush_IFID=flush_IDEX=1, PC_en=1.
- **Memory wait:** mem_req=1 with ready low for 3 cycles, MEM_TIMEOUT=16 → 3 cycles of upstream enables 0 and flush_MEMWB=1, then RUN, mem_err=0.
- **Timeout:** ready never asserts, MEM_TIMEOUT=4 → ERR after the 5th wait cycle, mem_err=1 and held. Asserting rst_n_HAZ low → all outputs 0, state RUN.
- **HAZ_PERF_CNT_EN:** after the two scenarios above (load-use, then a 3-cycle wait) → stall_cycles=4, flush_events=0; after one branch → flush_events=1.
